serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
- Parametrised multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry chain between steps.
- Operands enter and results leave through valid/ready handshakes.
- Used where area matters more than latency, e.g. in accumulators and checksum datapaths, in place of a WIDTH-wide ripple adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- DIGIT, 1, bits processed per cycle; must be at least 1 and divide WIDTH. A violation is a fatal elaboration error.
- STEPS is derived as WIDTH/DIGIT and is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned; see the optional feature for signed use).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. The internal operand registers, carry register and step counter are all cleared to 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at a rising edge:
    - latch a and b into right-shift registers;
    - carry register <= cin;
    - step counter <= 0;
    - go to RUN.
  - RUN: in_ready=0. Each cycle:
    - add the low DIGIT bits of each operand register plus the carry register;
    - store the DIGIT-bit digit sum into the top DIGIT bits of the result shift register, shifting it right by DIGIT;
    - carry register <= digit carry-out;
    - shift the operand registers right by DIGIT;
    - counter += 1.
    - On the edge where the counter equals STEPS-1, go to DONE.
  - DONE: out_valid=1, and sum and cout hold stable. On out_valid&&out_ready, go to IDLE; out_valid drops on that edge.
- Latency: operands accepted at edge E0; out_valid rises after edge E(STEPS). With out_ready tied high, throughput is one result per STEPS+2 cycles.
- in_ready is low in RUN and DONE. in_valid and the a/b/cin inputs are ignored in those states and may change freely.
- There is no same-cycle accept in DONE. A new operand is accepted only after returning to IDLE.
- Backpressure: DONE holds indefinitely while out_ready=0. sum and cout must not change while out_valid=1.
- Width rules:
  - Each digit add is (DIGIT+1) bits wide. The MSB of that add is the step carry.
  - cout is the carry from the final step.
  - sum is exact modulo 2^WIDTH.
- Boundary cases:
  - WIDTH=DIGIT (STEPS=1): RUN lasts exactly 1 cycle.
  - WIDTH=DIGIT=1: results must match the full-adder truth table for all 8 input combinations.
- Reset mid-operation: asserting rst_n low in RUN or DONE aborts immediately. All outputs take their reset values, and no partial result is ever presented.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - adds output port ovf (output, 1 bit), the two's-complement signed overflow;
  - ovf = (carry into bit WIDTH-1) XOR cout;
  - the carry into bit WIDTH-1 is taken inside the final step's digit add; for DIGIT=1 it is the carry register value entering the last step;
  - ovf is registered with sum and cout, valid with out_valid, resets to 0, and is held under backpressure.
- When undefined: the ovf port and its logic are absent, and all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1; a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid rises 8 cycles after accept; sum=0x00, cout=1.
- WIDTH=8, DIGIT=4; a=0x3C, b=0x5A, cin=1 -> out_valid rises 2 cycles after accept; sum=0x97, cout=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0 throughout. Raising out_ready -> out_valid low and in_ready high on the next edge.
- Busy ignore: pulse in_valid with a=0x11, b=0x22 during RUN -> no effect; the in-flight result is unchanged and exactly one result is produced.
- Reset mid-RUN: assert rst_n low at step 3 of 8 -> outputs reset immediately. After release, a new operand pair a=0x10, b=0x20, cin=0 yields sum=0x30, cout=0.
- SERIAL_ADDER_OVF_EN, WIDTH=8 -> 0x7F+0x01+0 gives sum=0x80, cout=0, ovf=1; 0xFF+0x01+0 gives ovf=0, cout=1. Also run an exhaustive sweep for WIDTH=DIGIT=1.

Source files
------------

// File: rtl/serial_adder_n_if.sv
// Handshake bundle for serial_adder_n: operand channel (in_*), result channel
// (out_*) and the busy status flag.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial adder computing a + b + cin over WIDTH bits,
// DIGIT bits per clock, with a registered carry between steps.
// Optional macro SERIAL_ADDER_OVF_EN adds the two's-complement overflow flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit added per cycle, STEPS cycles in total
// DONE  | result presented with out_valid, held until out_ready
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_n_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $fatal(1, "serial_adder_n: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
    logic             accept;
    logic             last_step;
    logic [DIGIT:0]   dadd;
    logic [WIDTH-1:0] res_next;

    // Digit add is DIGIT+1 bits wide; its MSB becomes the next step's carry.
    assign dadd = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    // The new digit enters at the top so that after STEPS shifts the full sum is aligned.
    assign res_next = (res_q >> DIGIT) | (WIDTH'(dadd[DIGIT-1:0]) << (WIDTH - DIGIT));

    assign accept    = (state_q == S_IDLE) && bus.in_valid;
    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry chain and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            res_q   <= res_next;
            carry_q <= dadd[DIGIT];
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Carry into the operand MSB is recovered as a^b^s of that bit; the value left
    // by the final step is the overflow of the whole add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_RUN) begin
            ovf_q <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dadd[DIGIT-1] ^ dadd[DIGIT];
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = res_q;
    assign bus.cout      = carry_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: three instances (8/1, 8/4, 1/1) driven
// from vector tables plus hand-written backpressure, ignore and reset sequences.
module tb_serial_adder_n;
    logic clk;
    logic rst_n;

    int n_total;
    int n_pass;

    serial_adder_n_if #(.WIDTH(8)) ia ();
    serial_adder_n_if #(.WIDTH(8)) ib ();
    serial_adder_n_if #(.WIDTH(1)) ic ();

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    serial_adder_n #(.WIDTH(1), .DIGIT(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return ia.in_ready;
            1:       return ib.in_ready;
            default: return ic.in_ready;
        endcase
    endfunction

    function automatic logic vld(input int sel);
        case (sel)
            0:       return ia.out_valid;
            1:       return ib.out_valid;
            default: return ic.out_valid;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        case (sel)
            0: begin ia.in_valid = v; ia.a = a; ia.b = b; ia.cin = c; end
            1: begin ib.in_valid = v; ib.a = a; ib.b = b; ib.cin = c; end
            default: begin ic.in_valid = v; ic.a = a[0]; ic.b = b[0]; ic.cin = c; end
        endcase
    endtask

    task automatic sample(input int sel, output logic [7:0] s, output logic co, output logic ov);
        ov = 1'b0;
        case (sel)
            0: begin
                s = ia.sum; co = ia.cout;
`ifdef SERIAL_ADDER_OVF_EN
                ov = ia.ovf;
`endif
            end
            1: begin
                s = ib.sum; co = ib.cout;
`ifdef SERIAL_ADDER_OVF_EN
                ov = ib.ovf;
`endif
            end
            default: begin
                s = {7'b0, ic.sum}; co = ic.cout;
`ifdef SERIAL_ADDER_OVF_EN
                ov = ic.ovf;
`endif
            end
        endcase
    endtask

    // One full transaction; lat counts edges from accept to out_valid (capped at 100).
    task automatic xact(input int sel, input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output logic ov, output int lat);
        int guard;
        guard = 0;
        while (!rdy(sel) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        drive(sel, 1'b1, a, b, c);
        @(posedge clk); #1;
        drive(sel, 1'b0, a, b, c);
        lat = 0;
        while (!vld(sel) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        sample(sel, s, co, ov);
    endtask

    task automatic run_vec(input int sel, input vec_t v, input int exp_lat, input string tag);
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
        xact(sel, v.a, v.b, v.cin, s, co, ov, lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " sum"}, s, v.s);
        check({tag, " cout"}, co, v.co);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, ov, v.ov);
`endif
    endtask

    initial begin
        vec_t va[8];
        vec_t vb[4];
        vec_t vc[8];
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
        int         guard;
        int         nres;

        n_total = 0;
        n_pass  = 0;

        va[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        va[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        va[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        va[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        va[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        va[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        va[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        va[7] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1};

        vb[0] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1};
        vb[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vb[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vb[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

        // Full-adder truth table; 1-bit overflow is cin ^ cout.
        vc[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0};
        vc[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0, 1'b1};
        vc[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0, 1'b0};
        vc[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1, 1'b0};
        vc[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b0};
        vc[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1, 1'b0};
        vc[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1};
        vc[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1, 1'b0};

        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        ic.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", ia.in_ready, 1'b1);
        check("reset out_valid", ia.out_valid, 1'b0);
        check("reset busy", ia.busy, 1'b0);
        check("reset sum", ia.sum, 8'h00);
        check("reset cout", ia.cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", ia.ovf, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(0, va[i], 8, $sformatf("w8d1[%0d]", i));
        for (int i = 0; i < 4; i++) run_vec(1, vb[i], 2, $sformatf("w8d4[%0d]", i));
        for (int i = 0; i < 8; i++) run_vec(2, vc[i], 1, $sformatf("w1d1[%0d]", i));

        // Backpressure: result held for 5 cycles, released by out_ready.
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        xact(0, 8'h12, 8'h34, 1'b0, s, co, ov, lat);
        check("bp latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", ia.out_valid, 1'b1);
            check("bp sum", ia.sum, 8'h46);
            check("bp cout", ia.cout, 1'b0);
            check("bp in_ready", ia.in_ready, 1'b0);
            check("bp busy", ia.busy, 1'b1);
            @(posedge clk); #1;
        end
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", ia.out_valid, 1'b0);
        check("bp release in_ready", ia.in_ready, 1'b1);

        // Operand pulse during RUN must be ignored.
        drive(0, 1'b1, 8'h05, 8'h06, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h05, 8'h06, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 8'h11, 8'h22, 1'b1);
        check("ignore in_ready", ia.in_ready, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        drive(0, 1'b0, 8'h11, 8'h22, 1'b1);
        guard = 0;
        while (!ia.out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ignore sum", ia.sum, 8'h0B);
        check("ignore cout", ia.cout, 1'b0);
        nres = 0;
        for (int i = 0; i < 20; i++) begin
            if (ia.out_valid) nres++;
            @(posedge clk); #1;
        end
        check("ignore result count", nres, 1);

        // Reset at step 3 of 8.
        drive(0, 1'b1, 8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'hFF, 8'h01, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", ia.out_valid, 1'b0);
        check("midreset in_ready", ia.in_ready, 1'b1);
        check("midreset busy", ia.busy, 1'b0);
        check("midreset sum", ia.sum, 8'h00);
        check("midreset cout", ia.cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nres = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ia.out_valid || ia.busy) nres++;
        end
        check("midreset no partial result", nres, 0);
        xact(0, 8'h10, 8'h20, 1'b0, s, co, ov, lat);
        check("post reset latency", lat, 8);
        check("post reset sum", s, 8'h30);
        check("post reset cout", co, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
